// File: rtl/agex_issue_ctrl_pkg.sv
// Shared types for the DE->AGEX issue control slice.
package agex_issue_ctrl_pkg;

    // Architectural register id (R0..R7).
    typedef logic [2:0] lc3b_reg;

    // One in-flight instruction as seen by the hazard tracker.
    typedef struct packed {
        logic    valid;
        lc3b_reg dr_id;
        logic    dr_we;
        logic    sets_cc;
    } inflight_t;

    // Width of the AGEX control word that agex_cs_kill zeroes.
    localparam int AGEX_CS_WIDTH = 20;

    // Default number of downstream stages tracked (AGEX, MEM, SR).
    localparam int INFLIGHT_DEPTH = 3;

    // An entry blocks a reader of `id` only if it really writes that register.
    function automatic logic reg_match(input inflight_t e, input lc3b_reg id);
        return e.valid & e.dr_we & (e.dr_id == id);
    endfunction

endpackage

// File: rtl/agex_scoreboard.sv
// Shift-register tracker of in-flight destinations plus RAW/CC hazard detect.
// Entry 0 mirrors the AGEX latch, the last entry is the stage about to retire.
module agex_scoreboard
    import agex_issue_ctrl_pkg::*;
#(
    parameter int INFLIGHT = INFLIGHT_DEPTH
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      advance,      // downstream moving this cycle
    input  logic      kill_head,    // drop entry 0 regardless of advance
    input  inflight_t issue_entry,  // what enters AGEX when advancing
    input  logic      de_valid,
    input  lc3b_reg   de_sr1_id,
    input  logic      de_sr1_used,
    input  lc3b_reg   de_sr2_id,
    input  logic      de_sr2_used,
    input  logic      de_cc_used,
    output logic      hazard
);

    inflight_t entry_q [INFLIGHT];
    inflight_t entry_d [INFLIGHT];

    logic [INFLIGHT-1:0] sr1_hit;
    logic [INFLIGHT-1:0] sr2_hit;
    logic [INFLIGHT-1:0] cc_hit;

    // Per-entry comparators against the decoded sources.
    generate
        for (genvar gi = 0; gi < INFLIGHT; gi++) begin : g_cmp
            assign sr1_hit[gi] = reg_match(entry_q[gi], de_sr1_id);
            assign sr2_hit[gi] = reg_match(entry_q[gi], de_sr2_id);
            assign cc_hit[gi]  = entry_q[gi].valid & entry_q[gi].sets_cc;
        end
    endgenerate

    // No forwarding: any in-flight producer of a used source blocks issue.
    assign hazard = de_valid & ((de_sr1_used & (|sr1_hit))
                              | (de_sr2_used & (|sr2_hit))
                              | (de_cc_used  & (|cc_hit)));

    // Next tracker contents: shift when advancing, head kill wins over hold.
    always_comb begin
        for (int i = 0; i < INFLIGHT; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (advance) begin
            entry_d[0] = issue_entry;
            for (int i = 1; i < INFLIGHT; i++) begin
                entry_d[i] = entry_q[i-1];
            end
        end
        if (kill_head) begin
            entry_d[0].valid = 1'b0;
        end
    end

    // Tracker state register; reset drops all tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < INFLIGHT; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < INFLIGHT; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule

// File: rtl/agex_issue_ctrl.sv
// Issue control for the DE->AGEX latch bank: issue, bubble or hold each cycle.
module agex_issue_ctrl
    import agex_issue_ctrl_pkg::*;
#(
    parameter int INFLIGHT = INFLIGHT_DEPTH,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             de_valid,
    input  logic [2:0]       de_sr1_id,
    input  logic             de_sr1_used,
    input  logic [2:0]       de_sr2_id,
    input  logic             de_sr2_used,
    input  logic [2:0]       de_dr_id,
    input  logic             de_dr_we,
    input  logic             de_cc_used,
    input  logic             de_sets_cc,
    input  logic             agex_stall,
    input  logic             flush,
    output logic             de_stall,
    output logic             load_agex_npc,
    output logic             load_agex_ir,
    output logic             load_agex_sr1,
    output logic             load_agex_sr2,
    output logic             load_agex_cc,
    output logic             load_agex_drid,
    output logic             load_agex_cs,
    output logic             agex_cs_kill,
    output logic             agex_valid,
    output logic [CNT_W-1:0] hazard_cycles
);

    logic             hazard;
    logic             load_real;
    inflight_t        issue_entry;
    logic             agex_valid_q, agex_valid_d;
    logic [CNT_W-1:0] hazard_cycles_q, hazard_cycles_d;

    agex_scoreboard #(.INFLIGHT(INFLIGHT)) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .advance     (~agex_stall),
        .kill_head   (flush),
        .issue_entry (issue_entry),
        .de_valid    (de_valid),
        .de_sr1_id   (de_sr1_id),
        .de_sr1_used (de_sr1_used),
        .de_sr2_id   (de_sr2_id),
        .de_sr2_used (de_sr2_used),
        .de_cc_used  (de_cc_used),
        .hazard      (hazard)
    );

    // Priority mux: reset > flush > downstream stall > hazard > issue > empty.
    always_comb begin
        load_real       = 1'b0;
        load_agex_cs    = 1'b0;
        agex_cs_kill    = 1'b0;
        de_stall        = 1'b1;
        agex_valid_d    = agex_valid_q;
        hazard_cycles_d = hazard_cycles_q;
        issue_entry     = '0;
        if (!reset_n) begin
            // Held idle with DE frozen while reset is asserted.
        end else if (flush) begin
            load_agex_cs = 1'b1;
            agex_cs_kill = 1'b1;
            de_stall     = 1'b0;
            agex_valid_d = 1'b0;
        end else if (agex_stall) begin
            // Everything holds; tracker frozen by the scoreboard.
        end else if (hazard) begin
            load_agex_cs = 1'b1;
            agex_cs_kill = 1'b1;
            agex_valid_d = 1'b0;
            if (hazard_cycles_q != {CNT_W{1'b1}}) begin
                hazard_cycles_d = hazard_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (de_valid) begin
            load_real           = 1'b1;
            load_agex_cs        = 1'b1;
            de_stall            = 1'b0;
            agex_valid_d        = 1'b1;
            issue_entry.valid   = 1'b1;
            issue_entry.dr_id   = de_dr_id;
            issue_entry.dr_we   = de_dr_we;
            issue_entry.sets_cc = de_sets_cc;
        end else begin
            load_agex_cs = 1'b1;
            agex_cs_kill = 1'b1;
            de_stall     = 1'b0;
            agex_valid_d = 1'b0;
        end
    end

    assign load_agex_npc  = load_real;
    assign load_agex_ir   = load_real;
    assign load_agex_sr1  = load_real;
    assign load_agex_sr2  = load_real;
    assign load_agex_cc   = load_real;
    assign load_agex_drid = load_real;
    assign agex_valid     = agex_valid_q;
    assign hazard_cycles  = hazard_cycles_q;

    // AGEX valid flag and saturating hazard-bubble counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            agex_valid_q    <= 1'b0;
            hazard_cycles_q <= '0;
        end else begin
            agex_valid_q    <= agex_valid_d;
            hazard_cycles_q <= hazard_cycles_d;
        end
    end

endmodule

// File: tb/tb_agex_issue_ctrl.sv
// Directed bench for agex_issue_ctrl with hand-computed expectations.
module tb_agex_issue_ctrl;

    localparam int CW = 4;

    // Control pattern {de_stall, six real loads, load_cs, kill}.
    localparam logic [8:0] P_ISSUE = 9'b0_111111_1_0;
    localparam logic [8:0] P_HAZ   = 9'b1_000000_1_1;
    localparam logic [8:0] P_EMPTY = 9'b0_000000_1_1;
    localparam logic [8:0] P_STALL = 9'b1_000000_0_0;
    localparam logic [8:0] P_FLUSH = 9'b0_000000_1_1;
    localparam logic [8:0] P_RESET = 9'b1_000000_0_0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          de_valid;
    logic [2:0]    de_sr1_id;
    logic          de_sr1_used;
    logic [2:0]    de_sr2_id;
    logic          de_sr2_used;
    logic [2:0]    de_dr_id;
    logic          de_dr_we;
    logic          de_cc_used;
    logic          de_sets_cc;
    logic          agex_stall;
    logic          flush;
    logic          de_stall;
    logic          load_agex_npc, load_agex_ir, load_agex_sr1, load_agex_sr2;
    logic          load_agex_cc, load_agex_drid, load_agex_cs, agex_cs_kill;
    logic          agex_valid;
    logic [CW-1:0] hazard_cycles;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] ctl;
    assign ctl = {de_stall, load_agex_npc, load_agex_ir, load_agex_sr1, load_agex_sr2,
                  load_agex_cc, load_agex_drid, load_agex_cs, agex_cs_kill};

    agex_issue_ctrl #(.INFLIGHT(3), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .de_valid       (de_valid),
        .de_sr1_id      (de_sr1_id),
        .de_sr1_used    (de_sr1_used),
        .de_sr2_id      (de_sr2_id),
        .de_sr2_used    (de_sr2_used),
        .de_dr_id       (de_dr_id),
        .de_dr_we       (de_dr_we),
        .de_cc_used     (de_cc_used),
        .de_sets_cc     (de_sets_cc),
        .agex_stall     (agex_stall),
        .flush          (flush),
        .de_stall       (de_stall),
        .load_agex_npc  (load_agex_npc),
        .load_agex_ir   (load_agex_ir),
        .load_agex_sr1  (load_agex_sr1),
        .load_agex_sr2  (load_agex_sr2),
        .load_agex_cc   (load_agex_cc),
        .load_agex_drid (load_agex_drid),
        .load_agex_cs   (load_agex_cs),
        .agex_cs_kill   (agex_cs_kill),
        .agex_valid     (agex_valid),
        .hazard_cycles  (hazard_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic de(input logic v, input logic [2:0] s1, input logic s1u,
                      input logic [2:0] s2, input logic s2u, input logic [2:0] dr,
                      input logic we, input logic ccu, input logic scc);
        de_valid    = v;
        de_sr1_id   = s1;
        de_sr1_used = s1u;
        de_sr2_id   = s2;
        de_sr2_used = s2u;
        de_dr_id    = dr;
        de_dr_we    = we;
        de_cc_used  = ccu;
        de_sets_cc  = scc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        agex_stall = 1'b0;
        flush      = 1'b0;
        de(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset ctl", 32'(ctl), 32'(P_RESET));
        chk("reset agex_valid", 32'(agex_valid), 32'd0);
        chk("reset hazard_cycles", 32'(hazard_cycles), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // ADD R1 then ADD R2,R1,R3: three bubbles, consumer issues on the 4th cycle.
        de(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        #1 chk("raw producer ctl", 32'(ctl), 32'(P_ISSUE));
        tick();
        chk("raw producer agex_valid", 32'(agex_valid), 32'd1);
        de(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("raw bubble ctl", 32'(ctl), 32'(P_HAZ));
            tick();
            chk("raw bubble agex_valid", 32'(agex_valid), 32'd0);
        end
        #1 chk("raw consumer ctl", 32'(ctl), 32'(P_ISSUE));
        chk("raw hazard_cycles", 32'(hazard_cycles), 32'd3);
        tick();
        chk("raw consumer agex_valid", 32'(agex_valid), 32'd1);

        // Independent stream; includes a dr_we=0 entry with id R5 read later.
        de(1'b1, 3'd0, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        #1 chk("indep0 ctl", 32'(ctl), 32'(P_ISSUE));
        tick();
        de(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        #1 chk("indep1 ctl", 32'(ctl), 32'(P_ISSUE));
        tick();
        de(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
        #1 chk("indep2 nowe ctl", 32'(ctl), 32'(P_ISSUE));
        tick();
        de(1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        #1 chk("indep3 ctl", 32'(ctl), 32'(P_ISSUE));
        tick();
        chk("indep agex_valid", 32'(agex_valid), 32'd1);
        chk("indep hazard_cycles", 32'(hazard_cycles), 32'd3);

        // DE empty (fields would hit R3 in flight): empty bubbles, no count.
        de(1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("empty ctl", 32'(ctl), 32'(P_EMPTY));
            tick();
            chk("empty agex_valid", 32'(agex_valid), 32'd0);
        end
        chk("empty hazard_cycles", 32'(hazard_cycles), 32'd3);

        // Hazard pending under a 5-cycle downstream stall, then 3 bubbles.
        de(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        #1 chk("stall producer ctl", 32'(ctl), 32'(P_ISSUE));
        tick();
        de(1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        agex_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("stall ctl", 32'(ctl), 32'(P_STALL));
            tick();
            chk("stall agex_valid", 32'(agex_valid), 32'd1);
            chk("stall hazard_cycles", 32'(hazard_cycles), 32'd3);
        end
        agex_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("post-stall bubble ctl", 32'(ctl), 32'(P_HAZ));
            tick();
        end
        #1 chk("post-stall issue ctl", 32'(ctl), 32'(P_ISSUE));
        chk("post-stall hazard_cycles", 32'(hazard_cycles), 32'd6);
        tick();
        chk("post-stall agex_valid", 32'(agex_valid), 32'd1);

        // Flush while stalled kills the cc-setting AGEX entry.
        agex_stall = 1'b1;
        flush      = 1'b1;
        de(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        #1 chk("flush ctl", 32'(ctl), 32'(P_FLUSH));
        tick();
        chk("flush agex_valid", 32'(agex_valid), 32'd0);
        flush      = 1'b0;
        agex_stall = 1'b0;
        de(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        #1 chk("br after flush ctl", 32'(ctl), 32'(P_ISSUE));
        tick();
        chk("br after flush agex_valid", 32'(agex_valid), 32'd1);

        // CC producer then BR: hazard; reset mid-hazard drops all tracking.
        de(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1);
        #1 chk("cc producer ctl", 32'(ctl), 32'(P_ISSUE));
        tick();
        de(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        #1 chk("cc hazard ctl", 32'(ctl), 32'(P_HAZ));
        chk("cc hazard count before", 32'(hazard_cycles), 32'd6);
        tick();
        chk("cc hazard count after", 32'(hazard_cycles), 32'd7);
        reset_n = 1'b0;
        #1 chk("midreset ctl", 32'(ctl), 32'(P_RESET));
        chk("midreset agex_valid", 32'(agex_valid), 32'd0);
        chk("midreset hazard_cycles", 32'(hazard_cycles), 32'd0);
        tick();
        reset_n = 1'b1;
        #1 chk("after reset br ctl", 32'(ctl), 32'(P_ISSUE));
        tick();
        chk("after reset agex_valid", 32'(agex_valid), 32'd1);

        // ADD R1,R1,R1 repeatedly: 3 bubbles per issue until the counter saturates.
        de(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        for (int g = 1; g <= 7; g++) begin
            #1 chk("sat issue ctl", 32'(ctl), 32'(P_ISSUE));
            tick();
            for (int k = 0; k < 3; k++) begin
                #1 chk("sat bubble ctl", 32'(ctl), 32'(P_HAZ));
                tick();
            end
            chk("sat hazard_cycles", 32'(hazard_cycles), (3 * g > 15) ? 32'd15 : 32'(3 * g));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
